ni_tx_packetizer: RTL
=====================

// Module: ni_tx_packetizer
// PURPOSE
//  Network-interface transmit side: drains the 64-bit NI FIFO entry {addr[63:32], data[31:0]} and
//  injects each entry into the router local port as a 2-flit packet (HEAD = address, TAIL = data).
//  Sits between the NI FIFO read port and the router injection link, with valid/ready on the link.
//  Accounts for the FIFO's 1-cycle registered read latency.
// PARAMETERS
//  DATA_WIDTH  64  FIFO entry width; the upper half is the address and the lower half is the data.
//  FLIT_W      34  flit width: {type[1:0], payload[31:0]}
//  CNT_W       16  width of the pkt_count statistics counter
// PORTS
//  clk         in   1        clock, all logic on posedge
//  reset       in   1        synchronous, active-high reset
//  tx_en       in   1        1 = may start new packets; 0 = finish the current packet, then idle
//  fifo_empty  in   1        empty flag from the NI FIFO
//  fifo_rd_en  out  1        FIFO read strobe (combinational); fifo_data is valid the next cycle
//  fifo_data   in   64       registered FIFO output {addr, data}
//  flit_out    out  34       flit to router: [33:32] type, [31:0] payload
//  flit_valid  out  1        flit_out holds a valid flit
//  flit_ready  in   1        router accepts flit_out this cycle
//  busy        out  1        state != IDLE
//  pkt_count   out  CNT_W    number of packets fully sent (TAIL accepted); wraps modulo 2^CNT_W
// BEHAVIOUR
//  Flit types: 2'b01 = HEAD, payload = addr[31:0]; 2'b11 = TAIL, payload = data[31:0]; 2'b00 = none.
//  FSM (state registered; transitions on posedge clk):
//   IDLE: fifo_rd_en = tx_en & !fifo_empty. If fifo_rd_en = 1 -> WAIT, else stay.
//   WAIT: fifo_data is valid; capture it into entry_q -> HEAD. No valid flit is driven.
//   HEAD: flit_valid = 1, flit_out = {2'b01, entry_q[63:32]}. On flit_ready -> TAIL.
//   TAIL: flit_valid = 1, flit_out = {2'b11, entry_q[31:0]}. On flit_ready: pkt_count += 1;
//         if tx_en & !fifo_empty then fifo_rd_en = 1 (same cycle) -> WAIT, else -> IDLE.
//  Handshake: a flit transfers on a cycle where flit_valid & flit_ready are both 1.
//   - Once flit_valid rises, flit_out is held stable until it is accepted.
//   - flit_valid never drops without acceptance, except on reset.
//  fifo_rd_en is only ever 1 when fifo_empty = 0: the FIFO is never popped while empty.
//  fifo_rd_en is never asserted in WAIT or HEAD.
//  Latency: rd_en cycle N -> HEAD valid at N+2 -> TAIL at N+3 (zero stall).
//   Sustained rate is 1 packet per 3 cycles.
//  flit_out is driven to 0 whenever flit_valid = 0.
//  tx_en is sampled only at packet start (IDLE or TAIL acceptance); a packet in progress always completes.
//  Reset (any state): next cycle state = IDLE, flit_valid = 0, flit_out = 0, fifo_rd_en = 0,
//   busy = 0, pkt_count = 0, entry_q = 0. A popped but unsent entry is discarded.
//  pkt_count wraps from all-ones to 0 with no flag.
// TESTING
//  1 Assert reset with the FIFO non-empty -> flit_valid = 0, flit_out = 0, fifo_rd_en = 0,
//    pkt_count = 0, busy = 0.
//  2 One entry 0x80000010_DEADBEEF, tx_en = 1, flit_ready = 1 -> rd_en pulse at cycle N;
//    HEAD 0x1_80000010 at N+2; TAIL 0x3_DEADBEEF at N+3; pkt_count = 1; back to IDLE.
//  3 flit_ready = 0 for 5 cycles during HEAD -> flit_out/flit_valid stable, no rd_en;
//    HEAD sent when ready returns; TAIL on the following cycle.
//  4 Three entries queued, flit_ready = 1 -> rd_en pulses every 3 cycles, 6 flits in order
//    H/T/H/T/H/T, pkt_count = 3.
//  5 tx_en = 0 with a non-empty FIFO -> no rd_en. Drop tx_en in HEAD -> TAIL still sent,
//    then IDLE with no further read.
//  6 Reset in HEAD with flit_ready = 0 -> flit_valid = 0 next cycle, pkt_count = 0.
//    Separately: force pkt_count = 0xFFFF and send one packet -> pkt_count = 0x0000.

Source files
------------

// File: rtl/ni_tx_packetizer_if.sv
// NI transmit-side bundle: FIFO read port plus the router injection link.
// The master side is the packetizer; the slave side is the FIFO/router environment.
interface ni_tx_packetizer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int FLIT_W     = 34
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [FLIT_W-1:0]     flit_out;
  logic                  flit_valid;
  logic                  flit_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flit_ready,
    output fifo_rd_en,
    output flit_out,
    output flit_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output flit_ready,
    input  fifo_rd_en,
    input  flit_out,
    input  flit_valid
  );
endinterface

// File: rtl/ni_tx_packetizer.sv
// Drains {addr, data} entries from the NI FIFO and injects each one into the router
// local port as a HEAD(addr) + TAIL(data) packet over a valid/ready link.
module ni_tx_packetizer #(
  parameter int DATA_WIDTH = 64,
  parameter int FLIT_W     = 34,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tx_en,
  ni_tx_packetizer_if.master    ni_if,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_pkt_count
);

  localparam int HALF_W = DATA_WIDTH / 2;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HEAD = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  state_t              r_state;
  logic [HALF_W-1:0]   r_tail_data;
  logic [FLIT_W-1:0]   r_flit_out;
  logic                r_flit_valid;
  logic                r_busy;
  logic [CNT_W-1:0]    r_pkt_count;

  logic                w_can_start;
  logic                w_fifo_rd_en;

  // FIFO pop strobe: only at packet start (IDLE, or TAIL being accepted), never while empty
  always_comb begin
    w_can_start  = i_tx_en & ~ni_if.fifo_empty;
    w_fifo_rd_en = 1'b0;
    if (i_reset) begin
      w_fifo_rd_en = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_fifo_rd_en = w_can_start;
        ST_TAIL: w_fifo_rd_en = ni_if.flit_ready & w_can_start;
        default: w_fifo_rd_en = 1'b0;
      endcase
    end
  end

  // Packet FSM with registered flit, valid, busy and statistics outputs.
  // The address half goes straight into the HEAD flit register; only the data half is kept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_tail_data  <= '0;
      r_flit_out   <= '0;
      r_flit_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_rd_en) begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_WAIT: begin
          r_tail_data  <= ni_if.fifo_data[HALF_W-1:0];
          r_flit_out   <= {TYPE_HEAD, ni_if.fifo_data[DATA_WIDTH-1:HALF_W]};
          r_flit_valid <= 1'b1;
          r_state      <= ST_HEAD;
        end

        ST_HEAD: begin
          if (ni_if.flit_ready) begin
            r_flit_out <= {TYPE_TAIL, r_tail_data};
            r_state    <= ST_TAIL;
          end else begin
            r_state    <= ST_HEAD;
          end
        end

        ST_TAIL: begin
          if (ni_if.flit_ready) begin
            r_pkt_count  <= r_pkt_count + CNT_W'(1);
            r_flit_out   <= '0;
            r_flit_valid <= 1'b0;
            // Back-to-back start: the pop issued this cycle lands in WAIT next cycle
            if (w_fifo_rd_en) begin
              r_state <= ST_WAIT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= ST_TAIL;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_flit_out   <= '0;
          r_flit_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign ni_if.fifo_rd_en = w_fifo_rd_en;
  assign ni_if.flit_out   = r_flit_out;
  assign ni_if.flit_valid = r_flit_valid;
  assign o_busy           = r_busy;
  assign o_pkt_count      = r_pkt_count;

endmodule
